// File: rtl/alu_exec_unit_pkg.sv
// Shared widths and op codes for the integer execute unit.
// ALU_MUL_EN enables the multiply ops and the extra pipeline stage that comes with them.
package alu_exec_unit_pkg;

  localparam int XLEN  = 32;
  localparam int OP_W  = 6;
  localparam int TAG_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD   = 6'd0,
    ALU_SUB   = 6'd1,
    ALU_SLL   = 6'd2,
    ALU_SLT   = 6'd3,
    ALU_SLTU  = 6'd4,
    ALU_XOR   = 6'd5,
    ALU_SRL   = 6'd6,
    ALU_SRA   = 6'd7,
    ALU_OR    = 6'd8,
    ALU_AND   = 6'd9,
    ALU_BEQ   = 6'd10,
    ALU_BNE   = 6'd11,
    ALU_BLT   = 6'd12,
    ALU_BGE   = 6'd13,
    ALU_BLTU  = 6'd14,
    ALU_BGEU  = 6'd15,
    ALU_JALR  = 6'd16,
    ALU_MUL   = 6'd17,
    ALU_MULH  = 6'd18,
    ALU_MULHU = 6'd19
  } alu_op_e;

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational ALU datapath: op/a/b -> result value and branch flag.
// Multiply ops exist only when ALU_MUL_EN is defined; otherwise they fall to the undefined-op path.
module alu_exec_unit_core
  import alu_exec_unit_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_val,
  output logic            o_br
);

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic [4:0]      w_shamt;
  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;

  assign w_sum   = i_a + i_b;
  assign w_diff  = i_a - i_b;
  assign w_shamt = i_b[4:0];
  assign w_eq    = (i_a == i_b);
  assign w_lt_s  = ($signed(i_a) < $signed(i_b));
  assign w_lt_u  = (i_a < i_b);

`ifdef ALU_MUL_EN
  logic [2*XLEN-1:0] w_prod_u;
  logic [XLEN-1:0]   w_mulh;

  // One unsigned multiplier serves all three ops; the signed high half is the
  // unsigned high half corrected for each negative operand.
  assign w_prod_u = {{XLEN{1'b0}}, i_a} * {{XLEN{1'b0}}, i_b};
  assign w_mulh   = w_prod_u[2*XLEN-1:XLEN]
                  - (i_a[XLEN-1] ? i_b : '0)
                  - (i_b[XLEN-1] ? i_a : '0);
`endif

  always_comb begin
    o_val = '0;
    o_br  = 1'b0;
    case (i_op)
      ALU_ADD:  o_val = w_sum;
      ALU_SUB:  o_val = w_diff;
      ALU_SLL:  o_val = i_a << w_shamt;
      ALU_SLT:  o_val = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_SLTU: o_val = {{(XLEN-1){1'b0}}, w_lt_u};
      ALU_XOR:  o_val = i_a ^ i_b;
      ALU_SRL:  o_val = i_a >> w_shamt;
      ALU_SRA:  o_val = $signed(i_a) >>> w_shamt;
      ALU_OR:   o_val = i_a | i_b;
      ALU_AND:  o_val = i_a & i_b;
      ALU_BEQ:  begin o_br = 1'b1; o_val = {{(XLEN-1){1'b0}},  w_eq};   end
      ALU_BNE:  begin o_br = 1'b1; o_val = {{(XLEN-1){1'b0}}, ~w_eq};   end
      ALU_BLT:  begin o_br = 1'b1; o_val = {{(XLEN-1){1'b0}},  w_lt_s}; end
      ALU_BGE:  begin o_br = 1'b1; o_val = {{(XLEN-1){1'b0}}, ~w_lt_s}; end
      ALU_BLTU: begin o_br = 1'b1; o_val = {{(XLEN-1){1'b0}},  w_lt_u}; end
      ALU_BGEU: begin o_br = 1'b1; o_val = {{(XLEN-1){1'b0}}, ~w_lt_u}; end
      ALU_JALR: o_val = {w_sum[XLEN-1:1], 1'b0};
`ifdef ALU_MUL_EN
      ALU_MUL:   o_val = w_prod_u[XLEN-1:0];
      ALU_MULH:  o_val = w_mulh;
      ALU_MULHU: o_val = w_prod_u[2*XLEN-1:XLEN];
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Fixed-latency integer execute unit feeding the ALU CDB (latency 2, or 3 with ALU_MUL_EN).
// Stages: S1 input latch -> [S2 with ALU_MUL_EN] -> output stage; rdy low freezes all stages.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_val,
  output logic             out_br,
  output logic             busy
);

  logic             r_s1_valid;
  logic [OP_W-1:0]  r_s1_op;
  logic [XLEN-1:0]  r_s1_a;
  logic [XLEN-1:0]  r_s1_b;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_o_valid;
  logic [TAG_W-1:0] r_o_tag;
  logic [XLEN-1:0]  r_o_val;
  logic             r_o_br;

  logic [XLEN-1:0]  w_core_val;
  logic             w_core_br;

`ifdef ALU_MUL_EN
  logic             r_s2_valid;
  logic [TAG_W-1:0] r_s2_tag;
  logic [XLEN-1:0]  r_s2_val;
  logic             r_s2_br;
`endif

  alu_exec_unit_core u_core (
    .i_op  (r_s1_op),
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .o_val (w_core_val),
    .o_br  (w_core_br)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_tag    <= '0;
      r_o_val    <= '0;
      r_o_br     <= 1'b0;
`ifdef ALU_MUL_EN
      r_s2_valid <= 1'b0;
`endif
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_o_valid  <= 1'b0;
`ifdef ALU_MUL_EN
      r_s2_valid <= 1'b0;
`endif
    end else if (rdy) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op  <= in_op;
        r_s1_a   <= in_a;
        r_s1_b   <= in_b;
        r_s1_tag <= in_tag;
      end
`ifdef ALU_MUL_EN
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_tag <= r_s1_tag;
        r_s2_val <= w_core_val;
        r_s2_br  <= w_core_br;
      end
      r_o_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_o_tag <= r_s2_tag;
        r_o_val <= r_s2_val;
        r_o_br  <= r_s2_br;
      end
`else
      r_o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_o_tag <= r_s1_tag;
        r_o_val <= w_core_val;
        r_o_br  <= w_core_br;
      end
`endif
    end
  end

  // The output stage only advances on rdy cycles, so gating with rdy broadcasts a
  // held result exactly once; a flushed result must not reach RS/ROB this cycle.
  assign out_valid = r_o_valid & rdy & ~flush & ~rst;
  assign out_tag   = r_o_tag;
  assign out_val   = r_o_val;
  assign out_br    = r_o_br;

`ifdef ALU_MUL_EN
  assign busy = r_s1_valid | r_s2_valid | r_o_valid;
`else
  assign busy = r_s1_valid | r_o_valid;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: constant vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_exec_unit;

`ifdef ALU_MUL_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid;
  logic [5:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid, out_br, busy;
  logic [3:0]  out_tag;
  logic [31:0] out_val;

  int vectors     = 0;
  int miscompares = 0;
  int bcast_cnt   = 0;
  int n_active    = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
    logic        br;
    int          due;
  } pend_t;
  pend_t q[$];

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] ev;
    logic        eb;
  } vec_t;
  vec_t tbl[18];

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_tag(out_tag), .out_val(out_val), .out_br(out_br),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference semantics, computed with plain arithmetic from the op definitions.
  function automatic void ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] v, output logic br);
    longint sa, sb;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    v  = 32'd0;
    br = 1'b0;
    case (op)
      6'd0:  v = a + b;
      6'd1:  v = a - b;
      6'd2:  v = a << b[4:0];
      6'd3:  v = (sa < sb) ? 32'd1 : 32'd0;
      6'd4:  v = (a < b) ? 32'd1 : 32'd0;
      6'd5:  v = a ^ b;
      6'd6:  v = a >> b[4:0];
      6'd7:  v = 32'(sa >>> b[4:0]);
      6'd8:  v = a | b;
      6'd9:  v = a & b;
      6'd10: begin br = 1'b1; v = (a == b) ? 32'd1 : 32'd0; end
      6'd11: begin br = 1'b1; v = (a != b) ? 32'd1 : 32'd0; end
      6'd12: begin br = 1'b1; v = (sa < sb) ? 32'd1 : 32'd0; end
      6'd13: begin br = 1'b1; v = (sa >= sb) ? 32'd1 : 32'd0; end
      6'd14: begin br = 1'b1; v = (a < b) ? 32'd1 : 32'd0; end
      6'd15: begin br = 1'b1; v = (a >= b) ? 32'd1 : 32'd0; end
      6'd16: v = (a + b) & 32'hFFFF_FFFE;
`ifdef ALU_MUL_EN
      6'd17: v = pu[31:0];
      6'd18: v = 32'((sa * sb) >>> 32);
      6'd19: v = pu[63:32];
`endif
      default: v = 32'd0;
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  // Ops only move on cycles with rdy=1 and no flush/rst, so each op is due LAT such cycles after issue.
  task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic r, input logic f, input logic rs,
                      input logic [31:0] ev, input logic eb);
    logic exp_v;
    @(negedge clk);
    rst = rs; rdy = r; flush = f;
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    exp_v = (!rs && !f && r && q.size() > 0 && q[0].due == n_active);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_v) begin
      chk("out_tag", {28'd0, out_tag}, {28'd0, q[0].tag});
      chk("out_val", out_val, q[0].val);
      chk("out_br",  {31'd0, out_br}, {31'd0, q[0].br});
    end
    if (out_valid === 1'b1) bcast_cnt++;
    if (!rs) chk("busy", {31'd0, busy}, {31'd0, (q.size() != 0)});
    if (rs || f) begin
      q.delete();
    end else if (r) begin
      if (exp_v) void'(q.pop_front());
      if (v) q.push_back('{tag, ev, eb, n_active + LAT});
      n_active++;
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    logic [31:0] ev;
    logic        eb;
    ref_alu(op, a, b, ev, eb);
    step(1'b1, op, a, b, tag, 1'b1, 1'b0, 1'b0, ev, eb);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 6'd0, 32'd0, 32'd0, 4'd0, r, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    int base;
    logic [31:0] ev;
    logic        eb;

    tbl[0]  = '{6'd0,  32'd7,          32'hFFFF_FFFF, 4'd3,  32'd6,          1'b0};
    tbl[1]  = '{6'd1,  32'd5,          32'd7,         4'd4,  32'hFFFF_FFFE,  1'b0};
    tbl[2]  = '{6'd2,  32'd1,          32'h21,        4'd5,  32'd2,          1'b0};
    tbl[3]  = '{6'd3,  32'hFFFF_FFFF,  32'd1,         4'd6,  32'd1,          1'b0};
    tbl[4]  = '{6'd4,  32'hFFFF_FFFF,  32'd1,         4'd7,  32'd0,          1'b0};
    tbl[5]  = '{6'd5,  32'hF0F0_F0F0,  32'h0F0F_0F0F, 4'd8,  32'hFFFF_FFFF,  1'b0};
    tbl[6]  = '{6'd6,  32'h8000_0000,  32'd4,         4'd9,  32'h0800_0000,  1'b0};
    tbl[7]  = '{6'd7,  32'h8000_0000,  32'd4,         4'd1,  32'hF800_0000,  1'b0};
    tbl[8]  = '{6'd14, 32'd1,          32'd2,         4'd2,  32'd1,          1'b1};
    tbl[9]  = '{6'd8,  32'h12,         32'h21,        4'd10, 32'h33,         1'b0};
    tbl[10] = '{6'd9,  32'hFF00,       32'h0FF0,      4'd11, 32'h0F00,       1'b0};
    tbl[11] = '{6'd10, 32'd5,          32'd5,         4'd12, 32'd1,          1'b1};
    tbl[12] = '{6'd11, 32'd5,          32'd5,         4'd13, 32'd0,          1'b1};
    tbl[13] = '{6'd12, 32'hFFFF_FFFE,  32'd1,         4'd14, 32'd1,          1'b1};
    tbl[14] = '{6'd13, 32'hFFFF_FFFE,  32'd1,         4'd15, 32'd0,          1'b1};
    tbl[15] = '{6'd15, 32'hFFFF_FFFE,  32'd1,         4'd0,  32'd1,          1'b1};
    tbl[16] = '{6'd16, 32'h1003,       32'd4,         4'd5,  32'h1006,       1'b0};
    tbl[17] = '{6'd63, 32'd9,          32'd9,         4'd6,  32'd0,          1'b0};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;

    // Reset, then idle: nothing broadcast, not busy.
    step(1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    step(1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    chk("reset_out_tag", {28'd0, out_tag}, 32'd0);
    chk("reset_out_val", out_val, 32'd0);
    for (int i = 0; i < 10; i++) idle(1'b1);

    // Single ADD with explicit latency check.
    issue(6'd0, 32'd7, 32'hFFFF_FFFF, 4'd3);
    base = bcast_cnt;
    for (int i = 0; i < LAT + 2; i++) idle(1'b1);
    chk("add_single_bcast", bcast_cnt - base, 32'd1);

    // Constant table, issued back-to-back (SRA then BLTU are adjacent).
    for (int i = 0; i < 18; i++)
      step(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, 1'b1, 1'b0, 1'b0, tbl[i].ev, tbl[i].eb);
    for (int i = 0; i < LAT + 2; i++) idle(1'b1);

    // JALR held in the output stage across three rdy-low cycles.
    base = bcast_cnt;
    issue(6'd16, 32'h1003, 32'd4, 4'd5);
    for (int i = 0; i < LAT - 1; i++) idle(1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("jalr_once", bcast_cnt - base, 32'd1);

    // Flush with tags 6,7 in flight and tag 8 issuing in the flush cycle.
    base = bcast_cnt;
    issue(6'd0, 32'd1, 32'd1, 4'd6);
    issue(6'd0, 32'd2, 32'd2, 4'd7);
    ref_alu(6'd0, 32'd3, 32'd3, ev, eb);
    step(1'b1, 6'd0, 32'd3, 32'd3, 4'd8, 1'b1, 1'b1, 1'b0, ev, eb);
    for (int i = 0; i < LAT + 2; i++) idle(1'b1);
    chk("flush_no_bcast", bcast_cnt - base, 32'd0);

`ifdef ALU_MUL_EN
    issue(6'd18, 32'hFFFF_FFFF, 32'd2, 4'd9);
    for (int i = 0; i < LAT + 1; i++) idle(1'b1);
`endif

    // Randomized traffic with stalls, flushes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic        v, r, f, rs;
      logic [5:0]  op;
      logic [31:0] a, b;
      v  = ($urandom_range(0, 99) < 70);
      r  = ($urandom_range(0, 99) < 80);
      f  = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 199) < 1);
      op = 6'($urandom_range(0, 20));
      if (op == 6'd20) op = 6'($urandom_range(21, 63));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 4));
      ref_alu(op, a, b, ev, eb);
      step(v, op, a, b, 4'($urandom_range(0, 15)), r, f, rs, ev, eb);
    end
    for (int i = 0; i < LAT + 3; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
